// File: rtl/decrypt_pkg.sv
// Shared definitions for the decryption datapath: channel
// select encodings, demux state encoding and default widths.
package decrypt_pkg;

    localparam int DEF_MST_DWIDTH = 32;
    localparam int DEF_SYS_DWIDTH = 8;

    localparam logic [1:0] CH_CAESAR  = 2'd0;
    localparam logic [1:0] CH_SCYTALE = 2'd1;
    localparam logic [1:0] CH_ZIGZAG  = 2'd2;
    localparam logic [1:0] CH_INVALID = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } demux_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/demux_serializer.sv
// Word shift register and character counter; the current
// character is always the top slice of the shift register.
module demux_serializer
    import decrypt_pkg::*;
#(
    parameter int MST_DWIDTH = DEF_MST_DWIDTH,
    parameter int SYS_DWIDTH = DEF_SYS_DWIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  adv_i,
    input  logic [MST_DWIDTH-1:0] word_i,
    output logic [SYS_DWIDTH-1:0] char_o,
    output logic                  last_o
);

    localparam int N  = MST_DWIDTH / SYS_DWIDTH;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [MST_DWIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            sreg_d = word_i;
            cnt_d  = '0;
        end else if (adv_i) begin
            sreg_d = sreg_q << SYS_DWIDTH;
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign char_o = sreg_q[MST_DWIDTH-1 -: SYS_DWIDTH];
    assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/demux.sv
// Word-to-character demux onto three decryptor channels.
// DEMUX_SEL_CHECK_EN: drop select==3 words and pulse err_o.
module demux
    import decrypt_pkg::*;
#(
    parameter int MST_DWIDTH = DEF_MST_DWIDTH,
    parameter int SYS_DWIDTH = DEF_SYS_DWIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            select,
    input  logic [MST_DWIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [SYS_DWIDTH-1:0] data0_o,
    output logic [SYS_DWIDTH-1:0] data1_o,
    output logic [SYS_DWIDTH-1:0] data2_o,
    output logic                  valid0_o,
    output logic                  valid1_o,
    output logic                  valid2_o,
    output logic                  err_o
);

    demux_state_e          state_q, state_d;
    logic [1:0]            ch_q, ch_d;
    logic                  load, adv, last, accept;
    logic [SYS_DWIDTH-1:0] chr;
    logic [2:0]            act;
    logic [SYS_DWIDTH-1:0] hold_q [3];

    demux_serializer #(
        .MST_DWIDTH(MST_DWIDTH),
        .SYS_DWIDTH(SYS_DWIDTH)
    ) u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(load),
        .adv_i (adv),
        .word_i(data_i),
        .char_o(chr),
        .last_o(last)
    );

    assign ready_o = rst_n && ((state_q == ST_IDLE) || last);
    assign accept  = valid_i && ready_o;

`ifdef DEMUX_SEL_CHECK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        load    = 1'b0;
        adv     = 1'b0;
`ifdef DEMUX_SEL_CHECK_EN
        err_d   = 1'b0;
`endif
        if (state_q == ST_SEND && !last)
            adv = 1'b1;
        else if (state_q == ST_SEND)
            state_d = ST_IDLE;
        if (accept) begin
`ifdef DEMUX_SEL_CHECK_EN
            if (select == CH_INVALID) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                load    = 1'b1;
                ch_d    = select;
                state_d = ST_SEND;
            end
`else
            // Illegal select still occupies SEND; no valid decodes for it.
            load    = 1'b1;
            ch_d    = select;
            state_d = ST_SEND;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= CH_CAESAR;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

`ifdef DEMUX_SEL_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign act[0] = (state_q == ST_SEND) && (ch_q == CH_CAESAR);
    assign act[1] = (state_q == ST_SEND) && (ch_q == CH_SCYTALE);
    assign act[2] = (state_q == ST_SEND) && (ch_q == CH_ZIGZAG);

    // Idle channels keep showing the last character they carried.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) hold_q[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++)
                if (act[k]) hold_q[k] <= chr;
        end
    end

    assign valid0_o = act[0];
    assign valid1_o = act[1];
    assign valid2_o = act[2];
    assign data0_o  = act[0] ? chr : hold_q[0];
    assign data1_o  = act[1] ? chr : hold_q[1];
    assign data2_o  = act[2] ? chr : hold_q[2];

endmodule

// File: tb/tb_demux.sv
// Randomised and directed bench for demux against a queue model
// of the characters each accepted word must produce.
module tb_demux;

    logic        clk = 1'b0;
    logic        rst_n, valid_i, ready_o, err_o;
    logic [1:0]  select;
    logic [31:0] data_i;
    logic [7:0]  data0_o, data1_o, data2_o;
    logic        valid0_o, valid1_o, valid2_o;

    always #5 clk = ~clk;

    demux dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .select  (select),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data0_o (data0_o),
        .data1_o (data1_o),
        .data2_o (data2_o),
        .valid0_o(valid0_o),
        .valid1_o(valid1_o),
        .valid2_o(valid2_o),
        .err_o   (err_o)
    );

`ifdef DEMUX_SEL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [1:0] ch;
        logic [7:0] b;
    } ev_t;

    ev_t        q[$];
    ev_t        cur;
    bit         cur_v;
    logic [7:0] hold[3];
    bit         exp_err;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit acc,
                              input logic [1:0] s, input logic [31:0] d);
        exp_err = 1'b0;
        cur_v   = 1'b0;
        if (!r) begin
            q.delete();
            for (int k = 0; k < 3; k++) hold[k] = 8'h00;
        end else begin
            if (acc) begin
                if (s == 2'd3 && CHK) exp_err = 1'b1;
                else
                    for (int i = 0; i < 4; i++)
                        q.push_back('{ch: s, b: d[31-8*i -: 8]});
            end
            if (q.size() > 0) begin
                cur   = q.pop_front();
                cur_v = 1'b1;
                if (cur.ch != 2'd3) hold[cur.ch] = cur.b;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [1:0] s,
                        input logic [31:0] d, output bit acc);
        logic [2:0] ov;
        logic [7:0] od[3];
        bit         er;
        rst_n = r; valid_i = v; select = s; data_i = d;
        #1;
        ov = {valid2_o, valid1_o, valid0_o};
        od[0] = data0_o; od[1] = data1_o; od[2] = data2_o;
        er = r && (q.size() == 0);
        check("ready", 32'(ready_o), 32'(er));
        check("err", 32'(err_o), 32'(exp_err));
        for (int k = 0; k < 3; k++) begin
            check($sformatf("valid%0d", k), 32'(ov[k]),
                  32'(cur_v && cur.ch == 2'(k)));
            check($sformatf("data%0d", k), 32'(od[k]), 32'(hold[k]));
        end
        acc = r && v && er;
        @(posedge clk);
        #1;
        model_edge(r, acc, s, d);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1, 0, 2'($urandom), 32'($urandom), a);
    endtask

    task automatic send(input logic [1:0] s, input logic [31:0] d);
        bit a = 1'b0;
        for (int i = 0; i < 8 && !a; i++) step(1, 1, s, d, a);
        if (!a) check("send_timeout", 0, 1);
    endtask

    initial begin
        bit         a, pend, r, v;
        logic [1:0] s;
        logic [31:0] d;
        rst_n = 1'b0; valid_i = 1'b0; select = 2'd0; data_i = '0;
        @(posedge clk);
        #1;
        model_edge(0, 0, 0, 0);
        step(0, 0, 0, 0, a);
        step(0, 1, 1, 32'h12345678, a);

        send(2'd1, 32'hA1B2C3D4);
        idle(5);

        send(2'd0, 32'h11223344);
        send(2'd2, 32'h55667788);
        idle(5);

        step(1, 1, 0, 32'h99AABBCC, a);
        step(1, 0, 2, 32'h0, a);
        step(1, 0, 2, 32'h0, a);
        step(1, 0, 1, 32'h0, a);
        step(1, 0, 2, 32'h0, a);
        idle(2);

        step(1, 1, 0, 32'hDEADBEEF, a);
        step(1, 0, 0, 32'h0, a);
        step(0, 0, 0, 32'h0, a);
        step(0, 0, 0, 32'h0, a);
        step(1, 0, 0, 32'h0, a);

        send(2'd3, 32'hCAFEF00D);
        idle(6);
        send(2'd3, 32'hCAFEF00D);
        send(2'd1, 32'h0BADF00D);
        idle(5);

        pend = 1'b0; v = 1'b0; s = '0; d = '0;
        for (int i = 0; i < 600; i++) begin
            if (!pend) begin
                v = ($urandom_range(0, 9) < 7);
                s = 2'($urandom);
                d = $urandom;
            end
            r = ($urandom_range(0, 63) != 0);
            step(r, v, s, d, a);
            pend = r && v && !a;
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux.md
# demux

Front-end distribution stage of the message-decryption datapath. Accepts wide ciphertext words from the input interface, latches the channel select per word, and serialises each word MSB-first into SYS_DWIDTH-bit characters on exactly one of three decryptor channels (0 = Caesar, 1 = Scytale, 2 = ZigZag). Sits directly upstream of the decryptors, whose outputs the output multiplexer recombines under the same select encoding.

## Interface
- MST_DWIDTH, 32, input word width; must be an integer multiple of SYS_DWIDTH
- SYS_DWIDTH, 8, character width per channel output
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- select  in  2  target channel; sampled only on word acceptance
- data_i  in  MST_DWIDTH  input word
- valid_i  in  1  data_i valid
- ready_o  out  1  block can accept a word this cycle
- data0_o / data1_o / data2_o  out  SYS_DWIDTH  per-channel character
- valid0_o / valid1_o / valid2_o  out  1  per-channel character valid
- err_o  out  1  one-cycle pulse on rejected select (see Configuration)

## Operation
- N = MST_DWIDTH/SYS_DWIDTH characters per word (N=4 default); counter width clog2(N), minimum 1.
- Accept = valid_i && ready_o. On accept: word into shift register, select into channel register, counter cleared, state -> SEND.
- States: IDLE (ready_o=1, no valids), SEND (one character per cycle).
- SEND: emit data_i[MST-1 -: SYS] first, then successively lower slices; counter increments each cycle; after character N-1, state -> IDLE unless a new word is accepted that same cycle (stays SEND, counter reset).
- ready_o = (state==IDLE) || (state==SEND && counter==N-1). Back-to-back words stream with no gap.
- Only the latched channel's valid rises; other valids stay 0. Data outputs of non-active channels hold their last value. Active channel data changes only with its valid.
- valid_i while ready_o=0: ignored; upstream must hold the word (no loss, no capture).
- select==3 on accept: handled per Configuration; no channel valid ever asserts for it.
- Reset (any state, including mid-word): state IDLE, counter 0, remaining characters discarded, outputs cleared next edge.

## Timing
- Reset values: all dataN_o 0, all validN_o 0, err_o 0, ready_o 0 while rst_n=0, 1 in first cycle after release.
- Latency: word accepted at edge T -> character 0 valid in cycle T+1, character N-1 in cycle T+N.
- Throughput: one word per N cycles sustained; 100% channel utilisation under continuous valid_i.
- Select change mid-word has no effect until the next accept.
- err_o asserts in cycle T+1 for a rejected word accepted at T, exactly one cycle.

## Configuration
- DEMUX_SEL_CHECK_EN defined: select==3 word is accepted (ready_o behaves normally), discarded immediately, block stays/returns IDLE, err_o pulses one cycle.
- Not defined: select==3 word is accepted and clocked through SEND for N cycles with all valids low (timing identical to a legal word); err_o tied 0.

## Structure
- Shared package decrypt_pkg: channel encodings CH_CAESAR=2'd0, CH_SCYTALE=2'd1, CH_ZIGZAG=2'd2, CH_INVALID=2'd3; state encoding; default widths. Also imported by the output mux and decryptors.
- One sub-module: demux_serializer (shift register, character counter, last-character flag); top holds FSM, select register, channel decode, err logic.

## Test plan
- Reset release, select=1, data_i=32'hA1B2C3D4 valid one cycle -> valid1_o cycles T+1..T+4 with A1,B2,C3,D4; valid0_o/valid2_o stay 0; ready_o low T+1..T+3.
- Continuous valid_i, words 32'h11223344 (sel 0) then 32'h55667788 (sel 2) -> 11,22,33,44 on ch0 then 55..88 on ch2 with zero idle cycles.
- select toggled 0->2 during SEND of a sel-0 word -> all 4 characters on ch0 only.
- rst_n low after second character of 32'hDEADBEEF -> only DE,AD emitted; all outputs 0 next edge; ready_o 1 after release.
- select=3, data 32'hCAFEF00D: with DEMUX_SEL_CHECK_EN -> err_o one pulse at T+1, ready_o high at T+1, no valids; without -> no valids for 4 cycles, err_o 0, ready_o high at T+4.
